alu_multicycle: RTL and testbench
=================================

Name: alu_multicycle

Overview:
- Parametrised, registered ALU for the MIPS-32 datapath; successor to the single-cycle combinational ALU.
- Adds WIDTH generalisation, signed-overflow and zero flags, shifts and SLT/NOR/XOR.
- Adds iterative unsigned multiply and divide with a HI/LO result pair.
- Sits between the ID/EX operand latches and the EX/MEM register. Valid/ready handshakes on both sides let the pipeline stall during multi-cycle ops.

Parameters:
- WIDTH, 32, operand and result width; must be a power of two, ≥8.
- SHAMT_W, $clog2(WIDTH), number of low input2 bits used as shift amount.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  operands and alu_control valid
- in_ready  output  1  block can accept an operation this cycle
- input1  input  WIDTH  operand A (dividend, multiplicand, shift source)
- input2  input  WIDTH  operand B (divisor, multiplier, shift amount)
- alu_control  input  4  operation select
- out_valid  output  1  result registers hold an unconsumed result
- out_ready  input  1  downstream consumes result
- alu_result  output  WIDTH  result; LO for MULT, quotient for DIVU
- alu_result_hi  output  WIDTH  HI for MULT, remainder for DIVU, else 0
- zero  output  1  alu_result == 0
- overflow  output  1  signed overflow (ADD/SUB only, else 0)
- div_by_zero  output  1  DIVU with input2 == 0

Behaviour:
- Reset: async on rst_n low. State=IDLE, all outputs and internal registers 0, in_ready=0 while reset is asserted.
- Opcodes, single-cycle:
  - 0000 AND, 0001 OR, 0011 XOR, 1100 NOR
  - 0010 ADD, 0110 SUB (modulo 2^WIDTH)
  - 0111 SLT (signed; result 1 or 0)
  - 1000 SLL, 1001 SRL, 1010 SRA (by input2[SHAMT_W-1:0])
  - Any other code: result 0, flags 0.
- Opcodes, multi-cycle: 1101 MULT (unsigned, 2·WIDTH product), 1110 DIVU (unsigned restoring).
- Handshake:
  - in_ready = (state==IDLE) && (!out_valid || out_ready).
  - Transfer occurs when in_valid && in_ready at a rising edge (edge k). Operands are captured at that edge and input ports are ignored afterwards.
  - out_valid stays high with stable outputs until out_valid && out_ready at an edge. It then clears unless a new result is written at the same edge.
  - A result written at the edge where the old one is consumed replaces it; out_valid stays 1.
- Latency:
  - Single-cycle ops, and DIVU with divisor 0: outputs and out_valid=1 after edge k+1... i.e. registered on edge k, visible in cycle k+1.
  - MULT/DIVU: FSM enters MUL or DIV and iterates one bit per edge for exactly WIDTH edges. Result written on edge k+WIDTH.
- FSM: IDLE -> MUL | DIV on acceptance of op 1101/1110 (nonzero divisor). MUL/DIV -> IDLE on the WIDTH-th iteration edge, writing the result. The iteration counter is $clog2(WIDTH)+1 bits.
- in_ready=0 throughout MUL/DIV.
- Iteration algorithms:
  - MULT: shift-add on a 2·WIDTH accumulator; {alu_result_hi, alu_result} = input1 × input2.
  - DIVU: restoring division; quotient -> alu_result, remainder -> alu_result_hi.
- Divide by zero: no iteration. alu_result = all ones, alu_result_hi = input1, div_by_zero=1.
- Flags:
  - zero computed from alu_result.
  - overflow for ADD = operand signs equal and result sign differs.
  - overflow for SUB = operand signs differ and result sign differs from input1.
  - Flags are registered with the result and held with it.
- Reset mid-operation: iteration aborted, no out_valid produced; the block returns to IDLE.

Test Plan:
- Reset: rst_n low mid-cycle -> all outputs 0 immediately. After release, in_ready=1, out_valid=0.
- ADD 0x7FFFFFFF+0x00000001 with out_ready=1 -> next cycle: alu_result=0x80000000, overflow=1, zero=0. SUB 5-5 -> result 0, zero=1. SLT 0xFFFFFFFF,1 -> 1. SRA 0x80000000 by 4 -> 0xF8000000.
- MULT 0xFFFFFFFF×0xFFFFFFFF -> after exactly 32 edges: alu_result_hi=0xFFFFFFFE, alu_result=0x00000001. in_ready=0 for the whole iteration. MULT 7×6 -> hi 0, lo 42.
- DIVU 100/7 -> after 32 edges: quotient 14, remainder 2. DIVU 0x1234/0 -> next cycle: result 0xFFFFFFFF, hi 0x1234, div_by_zero=1.
- Backpressure: out_ready=0 after ADD 3+4 -> result 7 held stable, in_ready=0 for 5 cycles. Then out_ready=1 together with in_valid OR 0xF0|0x0F -> 7 consumed, 0xFF appears next cycle, out_valid continuous.
- Reset asserted at iteration 10 of MULT -> out_valid never rises. After release, ADD 1+1 -> 2 with one-cycle latency.

Source files
------------

// File: rtl/alu_multicycle.sv
// -----------------------------------------------------------------------------
// alu_multicycle : registered MIPS-32 ALU with iterative MULT/DIVU and handshakes
// Revision: 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module alu_multicycle #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] input1,
  input  logic [WIDTH-1:0] input2,
  input  logic [3:0]       alu_control,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] alu_result,
  output logic [WIDTH-1:0] alu_result_hi,
  output logic             zero,
  output logic             overflow,
  output logic             div_by_zero
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  localparam logic [3:0] c_op_and  = 4'b0000;
  localparam logic [3:0] c_op_or   = 4'b0001;
  localparam logic [3:0] c_op_add  = 4'b0010;
  localparam logic [3:0] c_op_xor  = 4'b0011;
  localparam logic [3:0] c_op_sub  = 4'b0110;
  localparam logic [3:0] c_op_slt  = 4'b0111;
  localparam logic [3:0] c_op_sll  = 4'b1000;
  localparam logic [3:0] c_op_srl  = 4'b1001;
  localparam logic [3:0] c_op_sra  = 4'b1010;
  localparam logic [3:0] c_op_nor  = 4'b1100;
  localparam logic [3:0] c_op_mult = 4'b1101;
  localparam logic [3:0] c_op_divu = 4'b1110;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2
  } state_t;

  state_t               r_state, w_state_nxt;
  logic [WIDTH-1:0]     r_b;
  logic [2*WIDTH-1:0]   r_acc;
  logic [CNT_W-1:0]     r_cnt;
  logic [WIDTH-1:0]     r_result, r_result_hi;
  logic                 r_zero, r_overflow, r_div_by_zero, r_out_valid;

  logic                 w_accept, w_last, w_div0, w_legal, w_ov, w_dz, w_qbit;
  logic [WIDTH-1:0]     w_res, w_res_hi, w_sum, w_dif;
  logic [SHAMT_W-1:0]   w_shamt;
  logic [WIDTH:0]       w_mul_add, w_rem_sh, w_trial;
  logic [2*WIDTH-1:0]   w_mul_nxt, w_div_nxt, w_iter_nxt;

  assign in_ready      = rst_n && (r_state == S_IDLE) && (!r_out_valid || out_ready);
  assign w_accept      = in_valid && in_ready;
  assign w_div0        = (input2 == '0);
  assign w_last        = (r_cnt == CNT_W'(WIDTH - 1));
  assign out_valid     = r_out_valid;
  assign alu_result    = r_result;
  assign alu_result_hi = r_result_hi;
  assign zero          = r_zero;
  assign overflow      = r_overflow;
  assign div_by_zero   = r_div_by_zero;

  assign w_sum   = input1 + input2;
  assign w_dif   = input1 - input2;
  assign w_shamt = input2[SHAMT_W-1:0];

  // Single-cycle results, plus the no-iteration divide-by-zero case.
  always_comb begin
    w_res    = '0;
    w_res_hi = '0;
    w_ov     = 1'b0;
    w_dz     = 1'b0;
    w_legal  = 1'b1;
    case (alu_control)
      c_op_and: w_res = input1 & input2;
      c_op_or:  w_res = input1 | input2;
      c_op_xor: w_res = input1 ^ input2;
      c_op_nor: w_res = ~(input1 | input2);
      c_op_add: begin
        w_res = w_sum;
        w_ov  = (input1[WIDTH-1] == input2[WIDTH-1]) && (w_sum[WIDTH-1] != input1[WIDTH-1]);
      end
      c_op_sub: begin
        w_res = w_dif;
        w_ov  = (input1[WIDTH-1] != input2[WIDTH-1]) && (w_dif[WIDTH-1] != input1[WIDTH-1]);
      end
      c_op_slt: w_res = {{(WIDTH-1){1'b0}}, ($signed(input1) < $signed(input2))};
      c_op_sll: w_res = input1 << w_shamt;
      c_op_srl: w_res = input1 >> w_shamt;
      c_op_sra: w_res = $signed(input1) >>> w_shamt;
      c_op_divu: begin
        w_res    = '1;
        w_res_hi = input1;
        w_dz     = 1'b1;
      end
      default: w_legal = 1'b0;
    endcase
  end

  // One iteration step: shift-add multiply or restoring divide on r_acc.
  assign w_mul_add  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_b} : '0);
  assign w_mul_nxt  = {w_mul_add, r_acc[WIDTH-1:1]};
  assign w_rem_sh   = r_acc[2*WIDTH-1:WIDTH-1];
  assign w_trial    = w_rem_sh - {1'b0, r_b};
  assign w_qbit     = !w_trial[WIDTH];
  assign w_div_nxt  = {(w_qbit ? w_trial[WIDTH-1:0] : w_rem_sh[WIDTH-1:0]), r_acc[WIDTH-2:0], w_qbit};
  assign w_iter_nxt = (r_state == S_MUL) ? w_mul_nxt : w_div_nxt;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept && alu_control == c_op_mult)
          w_state_nxt = S_MUL;
        else if (w_accept && alu_control == c_op_divu && !w_div0)
          w_state_nxt = S_DIV;
      end
      S_MUL, S_DIV: if (w_last) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_b           <= '0;
      r_acc         <= '0;
      r_cnt         <= '0;
      r_result      <= '0;
      r_result_hi   <= '0;
      r_zero        <= 1'b0;
      r_overflow    <= 1'b0;
      r_div_by_zero <= 1'b0;
      r_out_valid   <= 1'b0;
    end else begin
      if (r_out_valid && out_ready) r_out_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            if (alu_control == c_op_mult) begin
              r_b   <= input1;
              r_acc <= {{WIDTH{1'b0}}, input2};
              r_cnt <= '0;
            end else if (alu_control == c_op_divu && !w_div0) begin
              r_b   <= input2;
              r_acc <= {{WIDTH{1'b0}}, input1};
              r_cnt <= '0;
            end else begin
              r_result      <= w_res;
              r_result_hi   <= w_res_hi;
              r_zero        <= w_legal && (w_res == '0);
              r_overflow    <= w_ov;
              r_div_by_zero <= w_dz;
              r_out_valid   <= 1'b1;
            end
          end
        end
        S_MUL, S_DIV: begin
          r_acc <= w_iter_nxt;
          r_cnt <= r_cnt + CNT_W'(1);
          if (w_last) begin
            r_result      <= w_iter_nxt[WIDTH-1:0];
            r_result_hi   <= w_iter_nxt[2*WIDTH-1:WIDTH];
            r_zero        <= (w_iter_nxt[WIDTH-1:0] == '0);
            r_overflow    <= 1'b0;
            r_div_by_zero <= 1'b0;
            r_out_valid   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_alu_multicycle.sv
// -----------------------------------------------------------------------------
// tb_alu_multicycle : directed + random checks of alu_multicycle vs. arithmetic model
// Revision: 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module tb_alu_multicycle;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b1;
  logic [3:0]   alu_control = '0;
  logic [W-1:0] input1 = '0, input2 = '0;
  logic         in_ready, out_valid, zero, overflow, div_by_zero;
  logic [W-1:0] alu_result, alu_result_hi;

  int checks = 0;
  int errors = 0;

  alu_multicycle #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .input1(input1), .input2(input2), .alu_control(alu_control),
    .out_valid(out_valid), .out_ready(out_ready),
    .alu_result(alu_result), .alu_result_hi(alu_result_hi),
    .zero(zero), .overflow(overflow), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Expected results straight from the arithmetic meaning of each opcode.
  function automatic void model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] lo, output logic [W-1:0] hi,
                                output logic z, output logic ov, output logic dz, output int lat);
    longint s;
    logic [63:0] p;
    logic legal;
    lo = '0; hi = '0; ov = 1'b0; dz = 1'b0; lat = 0; legal = 1'b1;
    case (op)
      4'b0000: lo = a & b;
      4'b0001: lo = a | b;
      4'b0011: lo = a ^ b;
      4'b1100: lo = ~(a | b);
      4'b0010: begin
        lo = a + b;
        s  = longint'($signed(a)) + longint'($signed(b));
        ov = (s != longint'($signed(lo)));
      end
      4'b0110: begin
        lo = a - b;
        s  = longint'($signed(a)) - longint'($signed(b));
        ov = (s != longint'($signed(lo)));
      end
      4'b0111: lo = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'b1000: lo = a << b[4:0];
      4'b1001: lo = a >> b[4:0];
      4'b1010: lo = $signed(a) >>> b[4:0];
      4'b1101: begin
        p   = {32'd0, a} * {32'd0, b};
        lo  = p[31:0];
        hi  = p[63:32];
        lat = W;
      end
      4'b1110: begin
        if (b == 0) begin
          lo = '1; hi = a; dz = 1'b1;
        end else begin
          lo = a / b; hi = a % b; lat = W;
        end
      end
      default: legal = 1'b0;
    endcase
    z = legal && (lo == 0);
  endfunction

  task automatic run_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] elo, ehi;
    logic ez, eov, edz;
    int elat, n;
    model(op, a, b, elo, ehi, ez, eov, edz, elat);
    @(negedge clk);
    in_valid = 1'b1; alu_control = op; input1 = a; input2 = b;
    #1 chk("in_ready_at_issue", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0; input1 = $urandom; input2 = $urandom; alu_control = 4'($urandom);
    n = 0;
    while (!out_valid && n < W + 4) begin
      chk("in_ready_busy", in_ready, 0);
      @(posedge clk); #1;
      n++;
    end
    chk($sformatf("latency op%b", op), n, elat);
    chk($sformatf("out_valid op%b", op), out_valid, 1);
    chk($sformatf("result op%b a%h b%h", op, a, b), alu_result, elo);
    chk($sformatf("result_hi op%b a%h b%h", op, a, b), alu_result_hi, ehi);
    chk($sformatf("zero op%b", op), zero, ez);
    chk($sformatf("overflow op%b", op), overflow, eov);
    chk($sformatf("div_by_zero op%b", op), div_by_zero, edz);
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    logic [3:0] rop;

    // Reset state
    #2;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_result", alu_result, 0);
    chk("rst_result_hi", alu_result_hi, 0);
    chk("rst_flags", {zero, overflow, div_by_zero}, 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    #1 chk("post_rst_in_ready", in_ready, 1);
    chk("post_rst_out_valid", out_valid, 0);

    // Directed cases
    run_op(4'b0010, 32'h7FFFFFFF, 32'h00000001);
    run_op(4'b0110, 32'd5, 32'd5);
    run_op(4'b0110, 32'h80000000, 32'd1);
    run_op(4'b0111, 32'hFFFFFFFF, 32'd1);
    run_op(4'b1010, 32'h80000000, 32'd4);
    run_op(4'b1000, 32'h00000001, 32'd31);
    run_op(4'b1100, 32'h0F0F0000, 32'h000000F0);
    run_op(4'b1011, 32'h12345678, 32'h9);
    run_op(4'b1101, 32'hFFFFFFFF, 32'hFFFFFFFF);
    run_op(4'b1101, 32'd7, 32'd6);
    run_op(4'b1110, 32'd100, 32'd7);
    run_op(4'b1110, 32'h1234, 32'd0);
    run_op(4'b1110, 32'd3, 32'd9);

    // Random operations, with small divisors mixed in
    for (int i = 0; i < 60; i++) begin
      rop = 4'($urandom_range(0, 15));
      ra  = $urandom;
      rb  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 9)) : $urandom;
      run_op(rop, ra, rb);
    end

    // Backpressure: hold ADD result, then consume while issuing OR
    @(posedge clk); #1;
    chk("drained", out_valid, 0);
    @(negedge clk); out_ready = 1'b0;
    run_op(4'b0010, 32'd3, 32'd4);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_hold_result", alu_result, 7);
      chk("bp_hold_valid", out_valid, 1);
      chk("bp_in_ready", in_ready, 0);
    end
    @(negedge clk);
    out_ready = 1'b1; in_valid = 1'b1; alu_control = 4'b0001;
    input1 = 32'hF0; input2 = 32'h0F;
    #1 chk("bp_in_ready_release", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp_replace_valid", out_valid, 1);
    chk("bp_replace_result", alu_result, 32'hFF);
    @(posedge clk); #1;
    chk("bp_consumed", out_valid, 0);

    // Reset in the middle of a MULT
    @(negedge clk);
    in_valid = 1'b1; alu_control = 4'b1101; input1 = 32'h12345678; input2 = 32'd3;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_result", alu_result, 0);
    chk("midrst_result_hi", alu_result_hi, 0);
    chk("midrst_in_ready", in_ready, 0);
    chk("midrst_out_valid", out_valid, 0);
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      chk("midrst_no_valid", out_valid, 0);
    end
    chk("midrst_idle_ready", in_ready, 1);
    run_op(4'b0010, 32'd1, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

`default_nettype wire
